alu_op_sequencer: RTL

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_op_sequencer.sv | 92 +++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand sequencer.
package alu_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    EXEC   = 2'd2,
    RESULT = 2'd3
  } state_t;

endpackage

// File: rtl/alu_op_sequencer.sv
// Sequences two operands and a mode bit into an external ALU, captures the
// combinational ALU result one cycle later and holds it until the sink takes it.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             op_m,
  output logic             in_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_m,
  input  logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  state_t state, state_nxt;
  logic   in_fire, res_fire;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD_A;
    else        state <= state_nxt;
  end

  // Next-state and state-decoded handshake outputs; in_ready depends on state only.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    in_fire   = 1'b0;
    res_fire  = 1'b0;
    unique case (state)
      LOAD_A: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        in_fire  = in_valid;
        if (in_valid) state_nxt = LOAD_B;
      end
      LOAD_B: begin
        in_ready = 1'b1;
        in_fire  = in_valid;
        if (in_valid) state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = RESULT;
      end
      RESULT: begin
        res_fire = res_valid & res_ready;
        if (res_fire) state_nxt = LOAD_A;
      end
      default: state_nxt = LOAD_A;
    endcase
  end

  // Operand/result/counter datapath. Operands are left in place after the
  // result is consumed so the ALU inputs only change on a new capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_m     <= 1'b0;
      res_data  <= '0;
      res_valid <= 1'b0;
      op_count  <= '0;
    end else begin
      if (state == LOAD_A && in_fire) alu_a <= in_data;
      if (state == LOAD_B && in_fire) begin
        alu_b <= in_data;
        alu_m <= op_m;
      end
      if (state == EXEC) begin
        res_data  <= alu_out;
        res_valid <= 1'b1;
      end
      if (res_fire) begin
        res_valid <= 1'b0;
        op_count  <= op_count + CNT_W'(1);
      end
    end
  end

endmodule
